// File: rtl/counter_down_load_pkg.sv
// rtl/counter_down_load_pkg.sv - shared counter definitions: state encoding and default width
//
// Purpose : state encoding and default width shared by the counter family.
// Contents: DEFAULT_WIDTH, state_t (IDLE=0, RUN=1, EXPIRED=2; 3 is unused).
package counter_down_load_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/counter_down_load.sv
// rtl/counter_down_load.sv - loadable down counter with terminal-count pulse and auto-reload
//
// Purpose : programmable interval timer / event-count limiter. Loads a start
//           value, decrements on enabled cycles, pulses tc for one cycle on
//           expiry, then stops at zero or reloads the last loaded value.
// Ports   : clk         rising-edge clock
//           rst         synchronous active-high reset
//           load        load data into count and reload register
//           data        start/reload value, sampled when load=1
//           en          decrement enable, honoured in RUN only
//           auto_reload 1 = periodic, 0 = one-shot; sampled in EXPIRED
//           count       registered counter value
//           zero        count == 0
//           tc          high exactly while in EXPIRED
//           busy        state != IDLE
module counter_down_load
  import counter_down_load_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      reload_reg <= '0;
      state      <= IDLE;
    end else if (load) begin
      // Loading zero goes straight to IDLE so it can never raise tc.
      count      <= data;
      reload_reg <= data;
      state      <= (data != '0) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        RUN: begin
          if (en) begin
            // count <= 1 rather than == 1 so a stray zero in RUN expires
            // instead of wrapping to all-ones.
            if (count <= ONE) begin
              count <= '0;
              state <= EXPIRED;
            end else begin
              count <= count - ONE;
            end
          end
        end
        EXPIRED: begin
          // One cycle only, independent of en.
          if (auto_reload && (reload_reg != '0)) begin
            count <= reload_reg;
            state <= RUN;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end
        default: begin
          // Unused encoding 2'd3 falls back to IDLE.
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode straight from the registers, no added latency.
  assign zero = (count == '0);
  assign tc   = (state == EXPIRED);
  assign busy = (state != IDLE);

endmodule
